wb_csr_commit: RTL and testbench
================================

# wb_csr_commit

Writeback-stage commit controller that drives the CSR file's access port and exception/return interface. It registers one instruction per cycle from the memory stage, performs csrrd/csrwr/csrxchg through the CSR read/write port, and commits exceptions and ertn. It selects the redirect target and squashes the pipeline for a programmable drain window after each flush. It sits between the memory stage and the CSR register file, and feeds the GPR write port.

## Interface
- FLUSH_HOLD, 2: squash-window length in cycles after a flush (legal 1..15).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ms_valid / ms_ready  in / out  1 / 1  memory-stage handshake.
- ms_pc  in  32  instruction PC.
- ms_csr_op  in  2  00 none, 01 csrrd, 10 csrwr, 11 csrxchg.
- ms_csr_num  in  14  CSR number.
- ms_rd_value  in  32  CSR write data (old rd).
- ms_rj_value  in  32  xchg write mask.
- ms_gr_we, ms_dest, ms_result  in  1, 5, 32  normal GPR writeback.
- ms_ex, ms_ecode, ms_esubcode, ms_vaddr  in  1, 6, 9, 32  exception already raised upstream.
- ms_ertn  in  1  instruction is ertn.
- csr_re, csr_we  out  1  CSR read/write enables.
- csr_num  out  14; csr_wmask, csr_wvalue  out  32  CSR port.
- csr_rvalue  in  32  CSR read data (combinational).
- has_int  in  1  pending enabled interrupt.
- csr_eentry_data, csr_era_pc  in  32  redirect sources.
- wb_ex, ertn_flush  out  1  commit strobes to the CSR file.
- wb_pc, wb_vaddr  out  32; wb_ecode  out  6; wb_esubcode  out  9.
- rf_we  out  1; rf_waddr  out  5; rf_wdata  out  32  GPR write.
- flush  out  1; flush_target  out  32  pipeline redirect.

## Operation
- ws register set: ws_valid, pc, csr_op, csr_num, rd/rj values, gr_we, dest, result, ex, ecode, esubcode, vaddr, ertn. Loaded on ms_valid && ms_ready && state==RUN.
- ms_ready = 1 in both states. WB never stalls.
- FSM RUN/DRAIN.
  - RUN: commit ws. If (ws_valid && ex_final) or ertn commit: go to DRAIN, cnt<=FLUSH_HOLD-1, ws_valid<=0.
  - DRAIN: inputs accepted and discarded (ws_valid<=0). cnt decrements; cnt==0 -> RUN (load resumes the following cycle).
- Interrupt tag (see Configuration): int_tag = ws_valid && has_int && !ws_ex. ex_final = ws_ex || int_tag. Tagged ecode=0x00, esubcode=0.
- Commit outputs (all gated by ws_valid && state==RUN):
  - wb_ex = ex_final.
  - ertn_flush = ws_ertn && !ex_final.
  - wb_pc=ws_pc, wb_vaddr=ws_vaddr, wb_ecode/esubcode = tagged or ws values.
  - csr_num = ws_csr_num.
  - csr_re = csr_op!=0.
  - csr_we = csr_op[1] && !ex_final.
  - csr_wvalue = ws_rd_value.
  - csr_wmask = 32'hffffffff for csrwr, ws_rj_value for csrxchg.
  - rf_we = (csr_op!=0 || ws_gr_we) && !ex_final, with rf_waddr=ws_dest.
  - rf_wdata = csr_rvalue (pre-write value) when csr_op!=0, else ws_result.
  - flush = wb_ex || ertn_flush.
  - flush_target = csr_eentry_data if wb_ex, else csr_era_pc.
- ex takes priority over ertn and CSR ops in the same instruction.

## Timing
- Reset (async): ws_valid=0, all ws fields 0, state=RUN, cnt=0. Every output is 0 while reset is asserted and in the first cycle after it.
- Latency: accepted at edge N, committed (all strobes) during cycle N+1. Single-cycle pulses.
- CSR write lands at the edge ending the commit cycle. rf_wdata carries the old value.
- Flush at cycle N+1. Instructions presented in cycles N+1 .. N+FLUSH_HOLD are dropped; the first loadable one is at cycle N+1+FLUSH_HOLD.
- Reset mid-DRAIN returns to RUN immediately.

## Configuration
- WB_CSR_INT_EN defined: has_int tags the committing instruction as an interrupt, as described in Operation.
- WB_CSR_INT_EN undefined: has_int is ignored; int_tag=0.

## Test plan
- csrwr num=0x30 rd=0x1234, CSR returns 0xAAAA -> one cycle later: csr_we=1, wmask=ffffffff, wvalue=0x1234, rf_wdata=0xAAAA, flush=0.
- csrxchg rj=0x0000ff00 -> csr_wmask=0x0000ff00, rf_we=1.
- ms_ex=1, ecode=0x08, pc=0x1c000100 with csrwr -> wb_ex=1, csr_we=0, rf_we=0, flush_target=eentry. Next FLUSH_HOLD=2 inputs dropped (no rf_we), third commits.
- ertn, era=0x1c000200 -> ertn_flush=1, flush_target=0x1c000200, wb_ex=0.
- has_int=1 on add with gr_we: WB_CSR_INT_EN -> wb_ex=1, ecode=0, rf_we=0. Without macro -> rf_we=1, flush=0.
- Assert reset during DRAIN -> outputs 0. After release, instruction committed on the second cycle.

Source files
------------

// File: rtl/wb_csr_commit.sv
// ---------------------------------------------------------------------------
// wb_csr_commit
//
// Writeback-stage commit controller. It registers one instruction per cycle
// from the memory stage, commits it during the following cycle, drives the
// CSR file's read/write port, commits exceptions and ertn, and selects the
// redirect target. After every flush the stage squashes incoming
// instructions for FLUSH_HOLD cycles so that the front of the pipeline can
// drain.
//
// Optional feature macro: WB_CSR_INT_EN
//   defined   : has_int tags the committing instruction as an interrupt
//               (ecode 0x00, esubcode 0) unless it already carries an
//               exception.
//   undefined : has_int is ignored.
//
// Parameters
//   FLUSH_HOLD   squash window after a flush, in cycles (legal 1..15)
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   ms_valid / ms_ready         memory-stage handshake
//   ms_pc .. ms_ertn            memory-stage instruction fields
//   csr_re, csr_we, csr_num,
//   csr_wmask, csr_wvalue       CSR read/write port
//   csr_rvalue                  CSR read data (combinational)
//   has_int                     pending enabled interrupt
//   csr_eentry_data, csr_era_pc redirect sources
//   wb_ex, ertn_flush           commit strobes to the CSR file
//   wb_pc, wb_vaddr,
//   wb_ecode, wb_esubcode       exception information
//   rf_we, rf_waddr, rf_wdata   GPR write port
//   flush, flush_target         pipeline redirect
//   dbg_state                   FSM state (0 RUN, 1 DRAIN)
//
// Handshake: an instruction transfers at a rising edge where ms_valid and
// ms_ready are both high. ms_ready is high whenever reset is released; the
// stage never back-pressures. A transferred instruction is either registered
// (committed in the next cycle) or discarded when it arrives inside a
// squash window.
// ---------------------------------------------------------------------------
module wb_csr_commit #(
  parameter int FLUSH_HOLD = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_valid,
  output logic        ms_ready,
  input  logic [31:0] ms_pc,
  input  logic [1:0]  ms_csr_op,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_rd_value,
  input  logic [31:0] ms_rj_value,
  input  logic        ms_gr_we,
  input  logic [4:0]  ms_dest,
  input  logic [31:0] ms_result,
  input  logic        ms_ex,
  input  logic [5:0]  ms_ecode,
  input  logic [8:0]  ms_esubcode,
  input  logic [31:0] ms_vaddr,
  input  logic        ms_ertn,
  output logic        csr_re,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  input  logic [31:0] csr_rvalue,
  input  logic        has_int,
  input  logic [31:0] csr_eentry_data,
  input  logic [31:0] csr_era_pc,
  output logic        wb_ex,
  output logic        ertn_flush,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        flush,
  output logic [31:0] flush_target,
  output logic        dbg_state
);

  localparam logic [1:0] OP_NONE    = 2'b00;
  localparam logic [1:0] OP_CSRWR   = 2'b10;
  localparam logic [1:0] OP_CSRXCHG = 2'b11;
  localparam logic [3:0] CNT_INIT   = 4'(FLUSH_HOLD - 1);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t      state;
  logic [3:0]  cnt;

  // Writeback register set
  logic        ws_valid;
  logic [31:0] ws_pc;
  logic [1:0]  ws_csr_op;
  logic [13:0] ws_csr_num;
  logic [31:0] ws_rd_value;
  logic [31:0] ws_rj_value;
  logic        ws_gr_we;
  logic [4:0]  ws_dest;
  logic [31:0] ws_result;
  logic        ws_ex;
  logic [5:0]  ws_ecode;
  logic [8:0]  ws_esubcode;
  logic [31:0] ws_vaddr;
  logic        ws_ertn;

  logic        commit;
  logic        int_tag;
  logic        ex_final;
  logic        flush_now;
  logic        load;

  assign ms_ready  = ~reset;
  assign dbg_state = (state == DRAIN);

  assign commit = ws_valid && (state == RUN);

`ifdef WB_CSR_INT_EN
  assign int_tag = ws_valid && has_int && !ws_ex;
`else
  assign int_tag = 1'b0;
`endif

  assign ex_final  = ws_ex || int_tag;
  // An exception outranks ertn; either one redirects the pipeline.
  assign flush_now = commit && (ex_final || ws_ertn);

  // The last DRAIN cycle (cnt == 0) already accepts the next instruction,
  // so the first loadable instruction arrives FLUSH_HOLD cycles after the
  // flush cycle. A RUN cycle that is itself flushing discards its input.
  assign load = ms_valid &&
                (((state == RUN) && !flush_now) ||
                 ((state == DRAIN) && (cnt == 4'd0)));

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      cnt      <= 4'd0;
      ws_valid <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (flush_now) begin
            state    <= DRAIN;
            cnt      <= CNT_INIT;
            ws_valid <= 1'b0;
          end else begin
            ws_valid <= load;
          end
        end
        DRAIN: begin
          if (cnt == 4'd0) begin
            state    <= RUN;
            ws_valid <= load;
          end else begin
            cnt      <= cnt - 4'd1;
            ws_valid <= 1'b0;
          end
        end
        default: begin
          state    <= RUN;
          cnt      <= 4'd0;
          ws_valid <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Payload registers: only captured for instructions that will commit
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_pc       <= 32'd0;
      ws_csr_op   <= 2'd0;
      ws_csr_num  <= 14'd0;
      ws_rd_value <= 32'd0;
      ws_rj_value <= 32'd0;
      ws_gr_we    <= 1'b0;
      ws_dest     <= 5'd0;
      ws_result   <= 32'd0;
      ws_ex       <= 1'b0;
      ws_ecode    <= 6'd0;
      ws_esubcode <= 9'd0;
      ws_vaddr    <= 32'd0;
      ws_ertn     <= 1'b0;
    end else if (load) begin
      ws_pc       <= ms_pc;
      ws_csr_op   <= ms_csr_op;
      ws_csr_num  <= ms_csr_num;
      ws_rd_value <= ms_rd_value;
      ws_rj_value <= ms_rj_value;
      ws_gr_we    <= ms_gr_we;
      ws_dest     <= ms_dest;
      ws_result   <= ms_result;
      ws_ex       <= ms_ex;
      ws_ecode    <= ms_ecode;
      ws_esubcode <= ms_esubcode;
      ws_vaddr    <= ms_vaddr;
      ws_ertn     <= ms_ertn;
    end
  end

  // ---------------------------------------------------------------------
  // Commit outputs; every strobe is a single-cycle pulse in the commit cycle
  // ---------------------------------------------------------------------
  always_comb begin
    csr_re       = 1'b0;
    csr_we       = 1'b0;
    csr_num      = 14'd0;
    csr_wmask    = 32'd0;
    csr_wvalue   = 32'd0;
    wb_ex        = 1'b0;
    ertn_flush   = 1'b0;
    wb_pc        = 32'd0;
    wb_vaddr     = 32'd0;
    wb_ecode     = 6'd0;
    wb_esubcode  = 9'd0;
    rf_we        = 1'b0;
    rf_waddr     = 5'd0;
    rf_wdata     = 32'd0;
    flush        = 1'b0;
    flush_target = 32'd0;
    if (commit) begin
      wb_ex       = ex_final;
      ertn_flush  = ws_ertn && !ex_final;
      wb_pc       = ws_pc;
      wb_vaddr    = ws_vaddr;
      wb_ecode    = int_tag ? 6'd0 : ws_ecode;
      wb_esubcode = int_tag ? 9'd0 : ws_esubcode;

      csr_num    = ws_csr_num;
      csr_re     = (ws_csr_op != OP_NONE);
      csr_we     = ws_csr_op[1] && !ex_final;
      csr_wvalue = ws_rd_value;
      if (ws_csr_op == OP_CSRWR) begin
        csr_wmask = 32'hffff_ffff;
      end else if (ws_csr_op == OP_CSRXCHG) begin
        csr_wmask = ws_rj_value;
      end

      // The CSR write lands at the end of this cycle, so csr_rvalue is
      // still the pre-write value that the instruction returns in rd.
      rf_we    = ((ws_csr_op != OP_NONE) || ws_gr_we) && !ex_final;
      rf_waddr = ws_dest;
      rf_wdata = (ws_csr_op != OP_NONE) ? csr_rvalue : ws_result;

      flush        = ex_final || (ws_ertn && !ex_final);
      flush_target = ex_final ? csr_eentry_data : csr_era_pc;
    end
  end

endmodule

// File: tb/tb_wb_csr_commit.sv
module tb_wb_csr_commit;

  localparam int H = 2;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [1:0]  op;
    logic [13:0] num;
    logic [31:0] rd;
    logic [31:0] rj;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] vaddr;
    logic        ertn;
  } instr_t;

  typedef struct packed {
    logic        wb_ex;
    logic        ertn_flush;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        flush;
    logic [31:0] flush_target;
  } out_t;

  logic        clk;
  logic        reset;
  logic        ms_valid;
  logic        ms_ready;
  logic [31:0] ms_pc;
  logic [1:0]  ms_csr_op;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_rd_value;
  logic [31:0] ms_rj_value;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  logic        ms_ex;
  logic [5:0]  ms_ecode;
  logic [8:0]  ms_esubcode;
  logic [31:0] ms_vaddr;
  logic        ms_ertn;
  logic        csr_re;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_rvalue;
  logic        has_int;
  logic [31:0] csr_eentry_data;
  logic [31:0] csr_era_pc;
  logic        wb_ex;
  logic        ertn_flush;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        flush;
  logic [31:0] flush_target;
  logic        dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard: instructions accepted by the model and awaiting commit
  instr_t exp_q[$];

  wb_csr_commit #(.FLUSH_HOLD(H)) dut (
    .clk(clk), .reset(reset),
    .ms_valid(ms_valid), .ms_ready(ms_ready),
    .ms_pc(ms_pc), .ms_csr_op(ms_csr_op), .ms_csr_num(ms_csr_num),
    .ms_rd_value(ms_rd_value), .ms_rj_value(ms_rj_value),
    .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result),
    .ms_ex(ms_ex), .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode),
    .ms_vaddr(ms_vaddr), .ms_ertn(ms_ertn),
    .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue),
    .has_int(has_int), .csr_eentry_data(csr_eentry_data), .csr_era_pc(csr_era_pc),
    .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flush(flush), .flush_target(flush_target), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input instr_t i);
    ms_valid    = i.valid;
    ms_pc       = i.pc;
    ms_csr_op   = i.op;
    ms_csr_num  = i.num;
    ms_rd_value = i.rd;
    ms_rj_value = i.rj;
    ms_gr_we    = i.gr_we;
    ms_dest     = i.dest;
    ms_result   = i.result;
    ms_ex       = i.ex;
    ms_ecode    = i.ecode;
    ms_esubcode = i.esub;
    ms_vaddr    = i.vaddr;
    ms_ertn     = i.ertn;
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    i.valid  = ($urandom_range(0, 3) != 0);
    i.pc     = $urandom;
    i.op     = 2'($urandom_range(0, 3));
    i.num    = 14'($urandom);
    i.rd     = $urandom;
    i.rj     = $urandom;
    i.gr_we  = 1'($urandom);
    i.dest   = 5'($urandom);
    i.result = $urandom;
    i.ex     = ($urandom_range(0, 7) == 0);
    i.ecode  = 6'($urandom);
    i.esub   = 9'($urandom);
    i.vaddr  = $urandom;
    i.ertn   = ($urandom_range(0, 7) == 0);
    return i;
  endfunction

  function automatic out_t observed();
    out_t o;
    o = '{wb_ex, ertn_flush, wb_pc, wb_vaddr, wb_ecode, wb_esubcode,
          csr_re, csr_we, csr_num, csr_wmask, csr_wvalue,
          rf_we, rf_waddr, rf_wdata, flush, flush_target};
    return o;
  endfunction

  // Reference: what the commit of instruction i must look like, given the
  // CSR-side inputs present during its commit cycle.
  function automatic out_t commit_model(input instr_t i, input logic hi,
                                        input logic [31:0] rv, input logic [31:0] ee,
                                        input logic [31:0] er);
    out_t o;
    logic is_int;
    logic takes_ex;
    logic is_csr;
`ifdef WB_CSR_INT_EN
    is_int = hi && !i.ex;
`else
    is_int = 1'b0;
`endif
    takes_ex = i.ex || is_int;
    is_csr   = (i.op != 2'b00);
    o.wb_ex        = takes_ex;
    o.ertn_flush   = i.ertn && !takes_ex;
    o.wb_pc        = i.pc;
    o.wb_vaddr     = i.vaddr;
    o.wb_ecode     = is_int ? 6'h00 : i.ecode;
    o.wb_esubcode  = is_int ? 9'h000 : i.esub;
    o.csr_re       = is_csr;
    o.csr_we       = (i.op == 2'b10 || i.op == 2'b11) && !takes_ex;
    o.csr_num      = i.num;
    o.csr_wmask    = (i.op == 2'b10) ? 32'hffff_ffff : (i.op == 2'b11) ? i.rj : 32'h0;
    o.csr_wvalue   = i.rd;
    o.rf_we        = (is_csr || i.gr_we) && !takes_ex;
    o.rf_waddr     = i.dest;
    o.rf_wdata     = is_csr ? rv : i.result;
    o.flush        = takes_ex || i.ertn;
    o.flush_target = takes_ex ? ee : er;
    return o;
  endfunction

  // Tests
  task automatic test_reset();
    instr_t i;
    reset = 1'b1;
    i = rand_instr();
    i.valid = 1'b1;
    drive(i);
    has_int = 1'b1;
    csr_rvalue = 32'h1111_2222;
    csr_eentry_data = 32'h3333_4444;
    csr_era_pc = 32'h5555_6666;
    tick();
    tick();
    @(negedge clk);
    n_cmp++; if (observed() !== out_t'(0)) begin n_fail++; $display("FAIL reset_outputs got %h want 0", observed()); end
    n_cmp++; if (ms_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ms_ready got %b want 0", ms_ready); end
    n_cmp++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL reset_state got %b want 0", dbg_state); end
    tick();
    reset = 1'b0;
    drive('0);
    has_int = 1'b0;
    @(negedge clk);
    n_cmp++; if (observed() !== out_t'(0)) begin n_fail++; $display("FAIL reset_first_cycle got %h want 0", observed()); end
    n_cmp++; if (ms_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ms_ready_after got %b want 1", ms_ready); end
    tick();
  endtask

  task automatic test_csrwr();
    instr_t i;
    i = '0;
    i.valid = 1'b1; i.pc = 32'h1c00_0010; i.op = 2'b10; i.num = 14'h30;
    i.rd = 32'h1234; i.dest = 5'd4;
    drive(i);
    tick();
    drive('0);
    csr_rvalue = 32'hAAAA;
    @(negedge clk);
    n_cmp++; if (csr_we !== 1'b1) begin n_fail++; $display("FAIL csrwr_we got %b want 1", csr_we); end
    n_cmp++; if (csr_re !== 1'b1) begin n_fail++; $display("FAIL csrwr_re got %b want 1", csr_re); end
    n_cmp++; if (csr_num !== 14'h30) begin n_fail++; $display("FAIL csrwr_num got %h want 30", csr_num); end
    n_cmp++; if (csr_wmask !== 32'hffff_ffff) begin n_fail++; $display("FAIL csrwr_wmask got %h want ffffffff", csr_wmask); end
    n_cmp++; if (csr_wvalue !== 32'h1234) begin n_fail++; $display("FAIL csrwr_wvalue got %h want 1234", csr_wvalue); end
    n_cmp++; if (rf_wdata !== 32'hAAAA) begin n_fail++; $display("FAIL csrwr_rf_wdata got %h want aaaa", rf_wdata); end
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4) begin n_fail++; $display("FAIL csrwr_rf got we=%b addr=%0d want we=1 addr=4", rf_we, rf_waddr); end
    n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("FAIL csrwr_flush got %b want 0", flush); end
    tick();
    @(negedge clk);
    n_cmp++; if (csr_we !== 1'b0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL csrwr_pulse got we=%b rf_we=%b want 0 0", csr_we, rf_we); end
    tick();
  endtask

  task automatic test_csrxchg();
    instr_t i;
    i = '0;
    i.valid = 1'b1; i.op = 2'b11; i.num = 14'h4; i.rd = 32'hdead_beef;
    i.rj = 32'h0000_ff00; i.dest = 5'd12;
    drive(i);
    tick();
    drive('0);
    csr_rvalue = 32'h0bad_f00d;
    @(negedge clk);
    n_cmp++; if (csr_wmask !== 32'h0000_ff00) begin n_fail++; $display("FAIL xchg_wmask got %h want 0000ff00", csr_wmask); end
    n_cmp++; if (csr_we !== 1'b1 || csr_wvalue !== 32'hdead_beef) begin n_fail++; $display("FAIL xchg_write got we=%b val=%h want 1 deadbeef", csr_we, csr_wvalue); end
    n_cmp++; if (rf_we !== 1'b1 || rf_wdata !== 32'h0bad_f00d) begin n_fail++; $display("FAIL xchg_rf got we=%b data=%h want 1 0badf00d", rf_we, rf_wdata); end
    tick();
  endtask

  task automatic test_exception_drain();
    instr_t a, b, c, d;
    a = '0; a.valid = 1'b1; a.pc = 32'h1c00_0100; a.op = 2'b10; a.num = 14'h30;
    a.ex = 1'b1; a.ecode = 6'h08; a.esub = 9'h3; a.vaddr = 32'h0000_4000; a.gr_we = 1'b1;
    b = '0; b.valid = 1'b1; b.gr_we = 1'b1; b.dest = 5'd3; b.result = 32'hb;
    c = '0; c.valid = 1'b1; c.gr_we = 1'b1; c.dest = 5'd5; c.result = 32'hc;
    d = '0; d.valid = 1'b1; d.gr_we = 1'b1; d.dest = 5'd6; d.result = 32'hd;
    csr_eentry_data = 32'h1c00_8000;
    csr_era_pc = 32'h1c00_0300;
    drive(a);
    tick();
    drive(b);
    @(negedge clk);
    n_cmp++; if (wb_ex !== 1'b1 || wb_ecode !== 6'h08 || wb_esubcode !== 9'h3) begin n_fail++; $display("FAIL ex_strobe got ex=%b ecode=%h esub=%h want 1 08 003", wb_ex, wb_ecode, wb_esubcode); end
    n_cmp++; if (wb_pc !== 32'h1c00_0100 || wb_vaddr !== 32'h0000_4000) begin n_fail++; $display("FAIL ex_pc got pc=%h vaddr=%h want 1c000100 00004000", wb_pc, wb_vaddr); end
    n_cmp++; if (csr_we !== 1'b0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL ex_suppress got csr_we=%b rf_we=%b want 0 0", csr_we, rf_we); end
    n_cmp++; if (flush !== 1'b1 || flush_target !== 32'h1c00_8000) begin n_fail++; $display("FAIL ex_flush got flush=%b tgt=%h want 1 1c008000", flush, flush_target); end
    n_cmp++; if (ertn_flush !== 1'b0) begin n_fail++; $display("FAIL ex_ertn got %b want 0", ertn_flush); end
    tick();
    drive(c);
    @(negedge clk);
    n_cmp++; if (rf_we !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL drain_1 got rf_we=%b flush=%b want 0 0", rf_we, flush); end
    n_cmp++; if (dbg_state !== 1'b1) begin n_fail++; $display("FAIL drain_state got %b want 1", dbg_state); end
    tick();
    drive(d);
    @(negedge clk);
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL drain_2 got rf_we=%b want 0", rf_we); end
    tick();
    drive('0);
    @(negedge clk);
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'hd) begin n_fail++; $display("FAIL drain_resume got we=%b addr=%0d data=%h want 1 6 d", rf_we, rf_waddr, rf_wdata); end
    tick();
  endtask

  task automatic test_ertn();
    instr_t i;
    i = '0; i.valid = 1'b1; i.ertn = 1'b1; i.pc = 32'h1c00_0040;
    drive(i);
    tick();
    drive('0);
    csr_era_pc = 32'h1c00_0200;
    csr_eentry_data = 32'h1c00_8000;
    @(negedge clk);
    n_cmp++; if (ertn_flush !== 1'b1 || wb_ex !== 1'b0) begin n_fail++; $display("FAIL ertn_strobe got ertn=%b ex=%b want 1 0", ertn_flush, wb_ex); end
    n_cmp++; if (flush !== 1'b1 || flush_target !== 32'h1c00_0200) begin n_fail++; $display("FAIL ertn_target got flush=%b tgt=%h want 1 1c000200", flush, flush_target); end
    tick(); tick(); tick();
  endtask

  task automatic test_interrupt();
    instr_t i;
    i = '0; i.valid = 1'b1; i.gr_we = 1'b1; i.dest = 5'd7; i.result = 32'h55;
    i.ecode = 6'h0b; i.esub = 9'h1;
    drive(i);
    tick();
    drive('0);
    has_int = 1'b1;
    @(negedge clk);
`ifdef WB_CSR_INT_EN
    n_cmp++; if (wb_ex !== 1'b1 || wb_ecode !== 6'h00 || wb_esubcode !== 9'h0) begin n_fail++; $display("FAIL int_tag got ex=%b ecode=%h esub=%h want 1 00 000", wb_ex, wb_ecode, wb_esubcode); end
    n_cmp++; if (rf_we !== 1'b0 || flush !== 1'b1) begin n_fail++; $display("FAIL int_effect got rf_we=%b flush=%b want 0 1", rf_we, flush); end
`else
    n_cmp++; if (wb_ex !== 1'b0) begin n_fail++; $display("FAIL int_ignored got ex=%b want 0", wb_ex); end
    n_cmp++; if (rf_we !== 1'b1 || flush !== 1'b0 || rf_wdata !== 32'h55) begin n_fail++; $display("FAIL int_effect got rf_we=%b flush=%b data=%h want 1 0 55", rf_we, flush, rf_wdata); end
`endif
    tick();
    has_int = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_in_drain();
    instr_t a, e;
    a = '0; a.valid = 1'b1; a.ex = 1'b1; a.ecode = 6'h01;
    e = '0; e.valid = 1'b1; e.gr_we = 1'b1; e.dest = 5'd9; e.result = 32'h99;
    drive(a);
    tick();
    drive('0);
    tick();
    reset = 1'b1;
    #1;
    n_cmp++; if (observed() !== out_t'(0)) begin n_fail++; $display("FAIL rst_drain_outputs got %h want 0", observed()); end
    n_cmp++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL rst_drain_state got %b want 0", dbg_state); end
    tick();
    reset = 1'b0;
    drive(e);
    @(negedge clk);
    n_cmp++; if (observed() !== out_t'(0)) begin n_fail++; $display("FAIL rst_release_first got %h want 0", observed()); end
    tick();
    drive('0);
    @(negedge clk);
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99) begin n_fail++; $display("FAIL rst_release_commit got we=%b addr=%0d data=%h want 1 9 99", rf_we, rf_waddr, rf_wdata); end
    tick();
  endtask

  task automatic test_random();
    instr_t cur, p;
    out_t exp, got;
    logic hi;
    logic [31:0] rv, ee, er;
    int drop_until;
    drive('0);
    tick(); tick(); tick();
    exp_q.delete();
    drop_until = 0;
    for (int c = 0; c < 400; c++) begin
      cur = rand_instr();
      hi  = ($urandom_range(0, 9) == 0);
      rv  = $urandom;
      ee  = $urandom;
      er  = $urandom;
      drive(cur);
      has_int = hi;
      csr_rvalue = rv;
      csr_eentry_data = ee;
      csr_era_pc = er;
      @(negedge clk);
      exp = '0;
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        exp = commit_model(p, hi, rv, ee, er);
      end
      got = observed();
      n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL random cycle %0d got %h want %h", c, got, exp); end
      // A flush in cycle c squashes inputs of cycles c .. c+H-1.
      if (exp.flush) drop_until = c + H;
      if (cur.valid && c >= drop_until) exp_q.push_back(cur);
      tick();
    end
    drive('0);
    has_int = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive('0);
    has_int = 1'b0;
    csr_rvalue = 32'h0;
    csr_eentry_data = 32'h0;
    csr_era_pc = 32'h0;
    test_reset();
    test_csrwr();
    test_csrxchg();
    test_exception_drain();
    test_ertn();
    test_interrupt();
    test_reset_in_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
